pim_cmd_sequencer: RTL

Command sequencer placed in front of the PIM module. It accepts PIM commands (host write, host read, in-memory ALU op) over a valid/ready port and buffers them in an in-order FIFO. It issues at most one command per cycle onto the PIM opcode/address/data inputs and returns read results over a valid/ready response port with backpressure. It is the only driver of the PIM module's command inputs.

---
 rtl/pim_pkg.sv | 27 ++
 rtl/pim_cmd_fifo.sv | 58 +++++
 rtl/pim_cmd_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/pim_pkg.sv
// Shared PIM opcode definitions, used by the command sequencer and by the
// PIM module's own control logic so both sides decode opcodes identically.
package pim_pkg;

    // PIM opcode encodings. 000-011 are ALU ops writing to addr_result,
    // 101 and 110 are no-ops that never reach the PIM.
    typedef enum logic [2:0] {
        OP_ALU0  = 3'b000,
        OP_ALU1  = 3'b001,
        OP_ALU2  = 3'b010,
        OP_ALU3  = 3'b011,
        OP_WRITE = 3'b100,
        OP_NOP   = 3'b101,
        OP_NOP2  = 3'b110,
        OP_READ  = 3'b111
    } pim_op_e;

    // ALU ops occupy the lower half of the opcode space.
    function automatic logic op_is_alu(input logic [2:0] op);
        return op[2] == 1'b0;
    endfunction

    function automatic logic op_is_nop(input logic [2:0] op);
        return (op == OP_NOP) || (op == OP_NOP2);
    endfunction

endpackage

// File: rtl/pim_cmd_fifo.sv
// In-order command FIFO for the PIM sequencer. Pointers carry one extra MSB
// so that full (MSBs differ, indices equal) and empty (pointers equal) are
// told apart without a separate occupancy counter.
module pim_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wptr_q, wptr_d;
    logic [PTR_W:0]   rptr_q, rptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[PTR_W-1:0]];

    // Next pointer values: advance on an accepted push/pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + PTR_ONE;
        if (do_pop)  rptr_d = rptr_q + PTR_ONE;
    end

    // Storage array; contents need no reset since empty gates the head.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[PTR_W-1:0]] <= wdata_i;
    end

    // Pointer registers with synchronous active-low reset (flushes the FIFO).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/pim_cmd_sequencer.sv
// Command sequencer in front of the PIM module: buffers commands in an
// in-order FIFO, issues at most one per cycle through a one-cycle issue
// register and returns READ results over a backpressured response slot.
// Optional build macro PIM_SEQ_PERF_EN adds perf_issued/perf_stall counters.
module pim_cmd_sequencer
    import pim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_opcode,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_a,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_b,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_result,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [2:0]            pim_opcode,
    output logic [ADDR_WIDTH-1:0] pim_addr_a,
    output logic [ADDR_WIDTH-1:0] pim_addr_b,
    output logic [ADDR_WIDTH-1:0] pim_addr_result,
    output logic [DATA_WIDTH-1:0] pim_write_data,
    input  logic [DATA_WIDTH-1:0] pim_result,
    output logic                  busy
`ifdef PIM_SEQ_PERF_EN
    ,
    output logic [31:0]           perf_issued,
    output logic [31:0]           perf_stall
`endif
);

    typedef struct packed {
        logic [2:0]            op;
        logic [ADDR_WIDTH-1:0] addr_a;
        logic [ADDR_WIDTH-1:0] addr_b;
        logic [ADDR_WIDTH-1:0] addr_result;
        logic [DATA_WIDTH-1:0] data;
    } cmd_t;

    localparam cmd_t IDLE_CMD = '{
        op:          OP_NOP,
        addr_a:      '0,
        addr_b:      '0,
        addr_result: '0,
        data:        '0
    };

    cmd_t                  in_cmd;
    cmd_t                  head_cmd;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;

    cmd_t                  iss_q, iss_d;
    logic                  iss_vld_q, iss_vld_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

    logic                  head_read;
    logic                  head_nop;
    logic                  head_direct;
    logic                  issue_is_read;
    logic                  read_ok;
    logic                  load;
    logic                  capture;

    assign in_cmd = '{
        op:          cmd_opcode,
        addr_a:      cmd_addr_a,
        addr_b:      cmd_addr_b,
        addr_result: cmd_addr_result,
        data:        cmd_data
    };

    // No pass-through: readiness depends only on the registered full flag.
    assign cmd_ready = !fifo_full;

    // NOP commands complete the handshake but are never stored, so they cannot
    // cost an issue slot between the commands around them in the queue.
    assign fifo_push = cmd_valid && cmd_ready && !op_is_nop(cmd_opcode);

    pim_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (in_cmd),
        .pop_i   (fifo_pop),
        .rdata_o (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head classification and pop rule.
    assign head_read     = (head_cmd.op == OP_READ);
    assign head_nop      = op_is_nop(head_cmd.op);
    assign head_direct   = (head_cmd.op == OP_WRITE) || op_is_alu(head_cmd.op);
    assign issue_is_read = (iss_q.op == OP_READ);
    // A READ may only issue if its result has somewhere to land next cycle,
    // and never right behind another READ still in the issue register.
    assign read_ok       = (!resp_valid_q || resp_ready) && !issue_is_read;
    assign load          = !fifo_empty && (head_direct || (head_read && read_ok));
    assign fifo_pop      = load || (!fifo_empty && head_nop);
    assign capture       = issue_is_read && (!resp_valid_q || resp_ready);

    // Next-state for the issue register and the response slot.
    always_comb begin
        iss_d        = IDLE_CMD;
        iss_vld_d    = 1'b0;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        if (load) begin
            iss_d     = head_cmd;
            iss_vld_d = 1'b1;
        end
        if (capture) begin
            resp_valid_d = 1'b1;
            resp_data_d  = pim_result;
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // Issue register and response slot; reset returns to idle NOP and drops
    // any pending response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            iss_q        <= IDLE_CMD;
            iss_vld_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            iss_q        <= iss_d;
            iss_vld_q    <= iss_vld_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign pim_opcode      = iss_q.op;
    assign pim_addr_a      = iss_q.addr_a;
    assign pim_addr_b      = iss_q.addr_b;
    assign pim_addr_result = iss_q.addr_result;
    assign pim_write_data  = iss_q.data;
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;
    assign busy            = !fifo_empty || iss_vld_q || resp_valid_q;

`ifdef PIM_SEQ_PERF_EN
    logic [31:0] perf_issued_q;
    logic [31:0] perf_stall_q;
    logic        read_stall;

    assign read_stall = !fifo_empty && head_read && !read_ok;

    // Free-running perf counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (iss_vld_q)  perf_issued_q <= perf_issued_q + 32'd1;
            if (read_stall) perf_stall_q  <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule
